pend_event_decoder: RTL and testbench

Decode-side counterpart to the 16:4 priority encoders: accepts 4-bit encoded event indices from producers (trap, interrupt, and cache-miss sources), decodes each one into a 16-bit pending register, and re-issues the highest-priority enabled pending event to the CPU control unit over a valid/ack handshake. This is the sticky event store between the event sources and the pipeline's trap-dispatch logic.

---
 rtl/pend_event_decoder_pkg.sv | 19 +
 rtl/pend_event_decoder_if.sv | 29 ++
 rtl/pend_event_decoder_prio_enc.sv | 23 ++
 rtl/pend_event_decoder.sv | 86 ++++++++
 tb/tb_pend_event_decoder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pend_event_decoder_pkg.sv
// Shared constants, types and helpers for the pending-event decoder.
package pend_event_decoder_pkg;

   localparam int unsigned N_EVT = 16;
   localparam int unsigned IDX_W = 4;

   localparam logic [0:0] PEND_ST_IDLE = 1'b0;
   localparam logic [0:0] PEND_ST_REQ  = 1'b1;

   // Big-endian event vector: bit [0] is index 15, bit [15] is index 0.
   typedef logic [0:N_EVT-1] evt_vec_t;
   typedef logic [0:IDX_W-1] evt_idx_t;

   // One-hot vector for an event index; numeric weight 2**idx lands on vec[15-idx].
   function automatic evt_vec_t idx_to_vec(input evt_idx_t idx);
      return N_EVT'(1) << idx;
   endfunction

endpackage

// File: rtl/pend_event_decoder_if.sv
// Post/offer/status bundle between event producers, the decoder and the consumer.
// Mask signals exist only when PEND_MASK_EN is defined.
interface pend_event_decoder_if;
   import pend_event_decoder_pkg::*;

   logic     post_vld;
   evt_idx_t post_idx;
   logic     req_vld;
   evt_idx_t req_idx;
   logic     req_ack;
   evt_vec_t pend;
   logic     ovf;
   logic     ovf_clr;
`ifdef PEND_MASK_EN
   logic     mask_wr;
   evt_vec_t mask_data;

   modport master (output post_vld, post_idx, req_ack, ovf_clr, mask_wr, mask_data,
                   input  req_vld, req_idx, pend, ovf);
   modport slave  (input  post_vld, post_idx, req_ack, ovf_clr, mask_wr, mask_data,
                   output req_vld, req_idx, pend, ovf);
`else
   modport master (output post_vld, post_idx, req_ack, ovf_clr,
                   input  req_vld, req_idx, pend, ovf);
   modport slave  (input  post_vld, post_idx, req_ack, ovf_clr,
                   output req_vld, req_idx, pend, ovf);
`endif

endinterface

// File: rtl/pend_event_decoder_prio_enc.sv
// Combinational 16:4 priority encoder over the eligible set; highest index wins.
module pend_prio_enc
   import pend_event_decoder_pkg::*;
(
   input  evt_vec_t elig_i,
   output evt_idx_t idx_c_o,
   output logic     any_c_o
);

   logic [N_EVT-1:0] elig_num;

   // Numeric view puts index i at bit i; later (higher) hits override earlier ones.
   always_comb begin
      elig_num = elig_i;
      idx_c_o  = '0;
      for (int unsigned i = 0; i < N_EVT; i++) begin
         if (elig_num[IDX_W'(i)]) idx_c_o = IDX_W'(i);
      end
   end

   assign any_c_o = |elig_i;

endmodule

// File: rtl/pend_event_decoder.sv
// Sticky pending-event store that re-offers the highest-priority eligible event.
// Optional enable mask compiled in with PEND_MASK_EN.
module pend_event_decoder
   import pend_event_decoder_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   pend_event_decoder_if.slave  ev_if
);

   logic [0:0] state_q, state_d;
   evt_vec_t   pend_q, pend_d;
   evt_idx_t   req_idx_q, req_idx_d;
   logic       req_vld_q, req_vld_d;
   logic       ovf_q, ovf_d;
   evt_vec_t   elig, set_vec, clr_vec;
   evt_idx_t   enc_idx;
   logic       enc_any;

`ifdef PEND_MASK_EN
   evt_vec_t mask_q, mask_d;

   always_comb mask_d = ev_if.mask_wr ? ev_if.mask_data : mask_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) mask_q <= '1;
      else     mask_q <= mask_d;
   end

   assign elig = pend_q & mask_q;
`else
   assign elig = pend_q;
`endif

   pend_prio_enc u_prio_enc (
      .elig_i  (elig),
      .idx_c_o (enc_idx),
      .any_c_o (enc_any)
   );

   // Offer FSM plus pend/ovf next state; a same-cycle post beats the ack clear.
   always_comb begin
      state_d   = state_q;
      req_idx_d = req_idx_q;
      clr_vec   = '0;
      set_vec   = ev_if.post_vld ? idx_to_vec(ev_if.post_idx) : '0;

      if (state_q == PEND_ST_IDLE) begin
         if (enc_any) begin
            state_d   = PEND_ST_REQ;
            req_idx_d = enc_idx;
         end
      end else begin
         if (ev_if.req_ack) begin
            clr_vec = idx_to_vec(req_idx_q);
            state_d = PEND_ST_IDLE;
         end
      end

      req_vld_d = (state_d == PEND_ST_REQ);
      pend_d    = (pend_q & ~clr_vec) | set_vec;
      ovf_d     = (|(set_vec & pend_q & ~clr_vec)) | (ovf_q & ~ev_if.ovf_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= PEND_ST_IDLE;
         pend_q    <= '0;
         req_idx_q <= '0;
         req_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         req_idx_q <= req_idx_d;
         req_vld_q <= req_vld_d;
         ovf_q     <= ovf_d;
      end
   end

   assign ev_if.req_vld = req_vld_q;
   assign ev_if.req_idx = req_idx_q;
   assign ev_if.pend    = pend_q;
   assign ev_if.ovf     = ovf_q;

endmodule

// File: tb/tb_pend_event_decoder.sv
// Self-checking bench for pend_event_decoder: directed scenarios plus random traffic
// against an event-level reference model.
module tb_pend_event_decoder;
   import pend_event_decoder_pkg::*;

   logic clk = 1'b0;
   logic rst;

   pend_event_decoder_if ev_if ();

   pend_event_decoder dut (
      .clk   (clk),
      .rst   (rst),
      .ev_if (ev_if)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model, indexed by event number (bit i = event i).
   bit [15:0] m_pend;
   bit [15:0] m_mask;
   int        m_offer;   // -1 when nothing is offered
   int        m_last;    // last offered index (req_idx holds it)
   bit        m_ovf;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend  = '0;
      m_mask  = '1;
      m_offer = -1;
      m_last  = 0;
      m_ovf   = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      int pidx;
      int clr;
      int cand;
      bit ovf_set;
      pidx = int'(ev_if.post_idx);
      clr  = (m_offer >= 0 && ev_if.req_ack) ? m_offer : -1;
      ovf_set = ev_if.post_vld && m_pend[pidx] && (clr != pidx);
      if (m_offer >= 0) begin
         if (ev_if.req_ack) m_offer = -1;
      end else begin
         cand = -1;
         for (int i = 0; i < 16; i++) if (m_pend[i] && m_mask[i]) cand = i;
         if (cand >= 0) begin
            m_offer = cand;
            m_last  = cand;
         end
      end
      if (clr >= 0) m_pend[clr] = 1'b0;
      if (ev_if.post_vld) m_pend[pidx] = 1'b1;
      m_ovf = ovf_set ? 1'b1 : (ev_if.ovf_clr ? 1'b0 : m_ovf);
`ifdef PEND_MASK_EN
      if (ev_if.mask_wr) m_mask = ev_if.mask_data;
`endif
   endtask

   task automatic check_outputs();
      chk("req_vld", 32'(ev_if.req_vld), 32'(m_offer >= 0));
      chk("req_idx", 32'(ev_if.req_idx), 32'(m_last));
      chk("pend",    32'(ev_if.pend),    32'(m_pend));
      chk("ovf",     32'(ev_if.ovf),     32'(m_ovf));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic clear_inputs();
      ev_if.post_vld = 1'b0;
      ev_if.post_idx = '0;
      ev_if.req_ack  = 1'b0;
      ev_if.ovf_clr  = 1'b0;
`ifdef PEND_MASK_EN
      ev_if.mask_wr   = 1'b0;
      ev_if.mask_data = '0;
`endif
   endtask

   task automatic drive(input bit pv, input int pi, input bit ack, input bit oc);
      ev_if.post_vld = pv;
      ev_if.post_idx = 4'(pi);
      ev_if.req_ack  = ack;
      ev_if.ovf_clr  = oc;
      tick();
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst = 1'b1;
      #1;
      chk("rst_vld",  32'(ev_if.req_vld), 32'd0);
      chk("rst_idx",  32'(ev_if.req_idx), 32'd0);
      chk("rst_pend", 32'(ev_if.pend),    32'd0);
      chk("rst_ovf",  32'(ev_if.ovf),     32'd0);
      #11 rst = 1'b0;

      // Single post of 5, then ack.
      drive(1, 5, 0, 0);
      chk("single_pend", 32'(ev_if.pend), 32'h0020);
      chk("single_vld0", 32'(ev_if.req_vld), 32'd0);
      drive(0, 0, 0, 0);
      chk("single_vld",  32'(ev_if.req_vld), 32'd1);
      chk("single_idx",  32'(ev_if.req_idx), 32'd5);
      drive(0, 0, 1, 0);
      chk("single_clr",  32'(ev_if.pend), 32'd0);
      chk("single_drop", 32'(ev_if.req_vld), 32'd0);

      // Lower priority offered first and not preempted.
      drive(1, 2, 0, 0);
      drive(1, 9, 0, 0);
      chk("prio_first", 32'(ev_if.req_idx), 32'd2);
      for (int k = 0; k < 5; k++) drive(0, 0, 0, 0);
      chk("prio_hold_vld", 32'(ev_if.req_vld), 32'd1);
      chk("prio_hold_idx", 32'(ev_if.req_idx), 32'd2);
      drive(0, 0, 1, 0);
      chk("prio_bubble", 32'(ev_if.req_vld), 32'd0);
      drive(0, 0, 0, 0);
      chk("prio_next_vld", 32'(ev_if.req_vld), 32'd1);
      chk("prio_next_idx", 32'(ev_if.req_idx), 32'd9);
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);

      // Overflow set/clear, then repost in the ack cycle.
      drive(1, 7, 0, 0);
      drive(1, 7, 0, 0);
      chk("ovf_set", 32'(ev_if.ovf), 32'd1);
      drive(0, 0, 0, 1);
      chk("ovf_clr", 32'(ev_if.ovf), 32'd0);
      drive(1, 7, 1, 0);
      chk("ovf_repost_pend", 32'(ev_if.pend), 32'h0080);
      chk("ovf_repost_ovf",  32'(ev_if.ovf),  32'd0);
      drive(0, 0, 0, 0);
      chk("ovf_reoffer_vld", 32'(ev_if.req_vld), 32'd1);
      chk("ovf_reoffer_idx", 32'(ev_if.req_idx), 32'd7);
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);

`ifdef PEND_MASK_EN
      // Masked event accumulates but is not offered until enabled.
      ev_if.mask_wr = 1'b1; ev_if.mask_data = 16'hFFFE;
      tick(); clear_inputs();
      drive(1, 0, 0, 0);
      for (int k = 0; k < 3; k++) drive(0, 0, 0, 0);
      chk("mask_pend", 32'(ev_if.pend), 32'h0001);
      chk("mask_vld",  32'(ev_if.req_vld), 32'd0);
      ev_if.mask_wr = 1'b1; ev_if.mask_data = 16'hFFFF;
      tick(); clear_inputs();
      drive(0, 0, 0, 0);
      chk("unmask_vld", 32'(ev_if.req_vld), 32'd1);
      chk("unmask_idx", 32'(ev_if.req_idx), 32'd0);
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 0);
`endif

      // Asynchronous reset while an offer is outstanding.
      drive(1, 3, 0, 0);
      drive(0, 0, 0, 0);
      drive(1, 3, 0, 0);
      chk("arst_pre_vld", 32'(ev_if.req_vld), 32'd1);
      chk("arst_pre_ovf", 32'(ev_if.ovf), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("arst_vld",  32'(ev_if.req_vld), 32'd0);
      chk("arst_pend", 32'(ev_if.pend), 32'd0);
      chk("arst_ovf",  32'(ev_if.ovf), 32'd0);
      model_reset();
      #1 rst = 1'b0;
      for (int k = 0; k < 4; k++) drive(0, 0, 0, 0);
      chk("arst_quiet", 32'(ev_if.req_vld), 32'd0);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         ev_if.post_vld = ($urandom % 10) < 3;
         ev_if.post_idx = 4'($urandom_range(0, 15));
         ev_if.req_ack  = ev_if.req_vld ? 1'($urandom % 2) : (($urandom % 8) == 0);
         ev_if.ovf_clr  = ($urandom % 10) == 0;
`ifdef PEND_MASK_EN
         ev_if.mask_wr   = ($urandom % 16) == 0;
         ev_if.mask_data = 16'($urandom);
`endif
         tick();
      end
      clear_inputs();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
